// File: rtl/debounce_if.sv
// -----------------------------------------------------------------------------
// debounce_if -- signal bundle between a debouncer and its user.
//
//   i_d     raw asynchronous input level (switch, pin)
//   i_en    qualification enable; 0 freezes the debouncer's FSM and counter
//   o_q     debounced, registered level
//   o_rise  one-cycle pulse when o_q goes 0->1
//   o_fall  one-cycle pulse when o_q goes 1->0
//   o_busy  1 while a candidate transition is being qualified
//
// master: the user side (drives i_d/i_en); slave: the debouncer itself.
// -----------------------------------------------------------------------------
interface debounce_if;
    logic i_d;
    logic i_en;
    logic o_q;
    logic o_rise;
    logic o_fall;
    logic o_busy;

    modport master (
        output i_d,
        output i_en,
        input  o_q,
        input  o_rise,
        input  o_fall,
        input  o_busy
    );

    modport slave (
        input  i_d,
        input  i_en,
        output o_q,
        output o_rise,
        output o_fall,
        output o_busy
    );
endinterface : debounce_if

// File: rtl/debounce.sv
// -----------------------------------------------------------------------------
// debounce -- two-flop synchronizer followed by a four-state qualification FSM.
// The output level changes only after DEB_CYCLES consecutive enabled samples of
// the synchronized input disagree with it; any shorter excursion is dropped and
// the stability counter cleared.
//
// Parameters
//   DEB_CYCLES  consecutive stable samples needed (2 .. 2**BW_CNT-1)
//   BW_CNT      stability counter width
//
// Ports
//   i_clk   single clock, rising edge
//   i_rstn  asynchronous active-low reset
//   bus     debounce_if.slave: i_d, i_en in; o_q, o_rise, o_fall, o_busy out
//
// All outputs are flops fed from the FSM next-state logic, so there is no
// combinational path from i_d to any output.
// -----------------------------------------------------------------------------
module debounce #(
    parameter int DEB_CYCLES = 4,
    parameter int BW_CNT     = 8
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    debounce_if.slave  bus
);

    typedef enum logic [1:0] {
        S_LOW,
        S_RISE,
        S_HIGH,
        S_FALL
    } state_t;

    localparam logic [BW_CNT-1:0] CNT_ZERO = '0;
    localparam logic [BW_CNT-1:0] CNT_ONE  = BW_CNT'(1);
    localparam logic [BW_CNT-1:0] CNT_LAST = BW_CNT'(DEB_CYCLES - 1);

    logic              ff1;
    logic              ff2;
    state_t            state;
    state_t            state_nxt;
    logic [BW_CNT-1:0] cnt;
    logic [BW_CNT-1:0] cnt_nxt;
    logic              rise_nxt;
    logic              fall_nxt;
    logic              q_r;
    logic              rise_r;
    logic              fall_r;
    logic              busy_r;

    // Synchronizer: straight flop-to-flop, nothing between ff1 and ff2, and it
    // keeps running while i_en is low so the sample is fresh when it returns.
    // NOTE: state flops use non-blocking (<=) so every flop samples the
    // pre-edge value of the others; blocking here would collapse ff1/ff2.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ff1 <= 1'b0;
            ff2 <= 1'b0;
        end else begin
            ff1 <= bus.i_d;
            ff2 <= ff1;
        end
    end

    // Next-state / counter / pulse logic. With i_en low everything keeps its
    // current value and no pulse is produced.
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // otherwise synthesis infers a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (bus.i_en) begin
            unique case (state)
                S_LOW: begin
                    if (ff2) begin
                        state_nxt = S_RISE;
                        cnt_nxt   = CNT_ONE;
                    end else begin
                        cnt_nxt   = CNT_ZERO;
                    end
                end
                S_RISE: begin
                    if (!ff2) begin
                        state_nxt = S_LOW;
                        cnt_nxt   = CNT_ZERO;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = S_HIGH;
                        cnt_nxt   = CNT_ZERO;
                        rise_nxt  = 1'b1;
                    end else begin
                        cnt_nxt   = cnt + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!ff2) begin
                        state_nxt = S_FALL;
                        cnt_nxt   = CNT_ONE;
                    end else begin
                        cnt_nxt   = CNT_ZERO;
                    end
                end
                S_FALL: begin
                    if (ff2) begin
                        state_nxt = S_HIGH;
                        cnt_nxt   = CNT_ZERO;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = S_LOW;
                        cnt_nxt   = CNT_ZERO;
                        fall_nxt  = 1'b1;
                    end else begin
                        cnt_nxt   = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = S_LOW;
                    cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

    // State register plus output flops. Outputs are loaded from the next-state
    // decode so o_q/o_busy change on the same edge as the state itself.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state  <= S_LOW;
            cnt    <= CNT_ZERO;
            q_r    <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            q_r    <= (state_nxt == S_HIGH) || (state_nxt == S_FALL);
            busy_r <= (state_nxt == S_RISE) || (state_nxt == S_FALL);
            rise_r <= rise_nxt;
            fall_r <= fall_nxt;
        end
    end

    assign bus.o_q    = q_r;
    assign bus.o_rise = rise_r;
    assign bus.o_fall = fall_r;
    assign bus.o_busy = busy_r;

endmodule : debounce

// File: doc/debounce.md
DEBOUNCE -- requirements
Module: debounce

Interface
REQ-001 Parameter: DEB_CYCLES, default 4, number of consecutive stable synchronized samples required before the output changes; legal range 2 to 2^BW_CNT-1.
REQ-002 Parameter: BW_CNT, default 8, stability counter width in bits.
REQ-003 Port: i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: i_rstn  input  1  asynchronous active-low reset.
REQ-005 Port: i_d  input  1  raw asynchronous input (switch, pin); may change at any time relative to i_clk.
REQ-006 Port: i_en  input  1  when 0, FSM and counter hold; synchronizer keeps running.
REQ-007 Port: o_q  output  1  debounced, registered level.
REQ-008 Port: o_rise  output  1  one-cycle registered pulse when o_q goes 0->1.
REQ-009 Port: o_fall  output  1  one-cycle registered pulse when o_q goes 1->0.
REQ-010 Port: o_busy  output  1  1 while a candidate transition is being qualified (state S_RISE or S_FALL).

Function
REQ-011 i_d SHALL pass through a two-flop synchronizer (ff1, ff2); the synchronized sample s is ff2; no logic between ff1 and ff2.
REQ-012 FSM states SHALL be S_LOW, S_RISE, S_HIGH, S_FALL; o_q = 1 exactly in S_HIGH and S_FALL.
REQ-013 S_LOW: s=1 -> S_RISE with cnt=1; else stay, cnt=0.
REQ-014 S_RISE: s=0 -> S_LOW, cnt=0; s=1 and cnt=DEB_CYCLES-1 -> S_HIGH, cnt=0, o_rise=1 for that cycle; else cnt+1.
REQ-015 S_HIGH: s=0 -> S_FALL with cnt=1; else stay, cnt=0.
REQ-016 S_FALL: s=1 -> S_HIGH, cnt=0; s=0 and cnt=DEB_CYCLES-1 -> S_LOW, cnt=0, o_fall=1 for that cycle; else cnt+1.
REQ-017 Latency: with i_d stable from the first sampling edge E, o_q SHALL change on edge E+DEB_CYCLES+1 (DEB_CYCLES+2 edges inclusive).
REQ-018 Any s pulse shorter than DEB_CYCLES cycles SHALL leave o_q unchanged, produce no o_rise/o_fall, and clear cnt.
REQ-019 o_rise and o_fall SHALL never both be 1, and each SHALL be 1 for exactly one cycle per o_q transition.
REQ-020 i_en=0 SHALL freeze state and cnt, force o_rise=o_fall=0, and hold o_q; qualification resumes from the frozen cnt when i_en returns to 1.
REQ-021 cnt SHALL never exceed DEB_CYCLES-1 and SHALL never wrap.
REQ-022 o_busy SHALL be registered from the state, with no combinational path from i_d to any output.

Reset
REQ-023 i_rstn=0 SHALL immediately (asynchronously) force ff1=ff2=0, state=S_LOW, cnt=0, o_q=0, o_rise=0, o_fall=0, o_busy=0.
REQ-024 Reset asserted mid-qualification SHALL abandon the transition with no pulse; after release the block behaves as from power-up.
REQ-025 If i_d=1 at reset release, o_q SHALL rise per REQ-017 and emit one o_rise.

Verification (DEB_CYCLES=4, 100 MHz clock)
REQ-026 Reset, i_en=1, i_d 0->1 before edge E, held -> o_busy=1 after E+2, o_q=1 and o_rise=1 after E+5, o_rise=0 after E+6.
REQ-027 From o_q=1, i_d low for 3 cycles then high -> o_q stays 1, o_fall never asserted, o_busy returns to 0.
REQ-028 Bounce burst: i_d toggles every 1-3 cycles for 40 cycles, then holds 0 -> exactly one o_fall, no o_rise, o_q=0 six edges after the final change.
REQ-029 i_en=0 for 5 cycles during S_RISE at cnt=2, i_d held 1 -> state and cnt frozen; o_q rises 2 edges after i_en returns to 1.
REQ-030 i_rstn pulsed low at cnt=3 in S_RISE -> all outputs 0 at once, no o_rise; with i_d=1 held, o_q rises 6 edges after release.
REQ-031 Random: 100 vectors, i_d changed at random sub-cycle offsets -> a reference model of REQ-011 to REQ-021 matches o_q, o_rise, o_fall and o_busy every cycle.
